// File: rtl/decode_3_input_serial_encoder_pkg.sv
// Shared types and helpers for the multi-hot to serial index encoder.
// Optional ENCODE_MSB_FIRST_EN reverses the emission order.
package decode_encode_pkg;

    localparam int N_DEF = 3;
    localparam int MAX_W = 256;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

    // True when exactly one bit of v is set.
    function automatic logic onehot_count_is_one(
        input logic [MAX_W-1:0] v
    );
        logic [MAX_W-1:0] low_cleared;
        low_cleared = v & (v - MAX_W'(1));
        return (v != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/decode_3_input_serial_encoder_if.sv
// Vector-in / index-out handshake bundle for the serial encoder.
// Macro ENCODE_MSB_FIRST_EN only affects the encoder, not this bundle.
interface decode_3_input_serial_encoder_if #(
    parameter int N = 3
);
    logic [(1<<N)-1:0] en_in;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      enc_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              zero_seen;

    modport master (
        output en_in, in_valid, out_ready,
        input  in_ready, enc_out, out_valid, out_last, zero_seen
    );

    modport slave (
        input  en_in, in_valid, out_ready,
        output in_ready, enc_out, out_valid, out_last, zero_seen
    );
endinterface

// File: rtl/decode_3_input_serial_encoder_ffs.sv
// Combinational find-first-set over a 2^N vector.
// ENCODE_MSB_FIRST_EN searches from the top bit instead of bit 0.
module find_first_set #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] vec,
    output logic [N-1:0]      idx,
    output logic              any
);
    localparam int W = 1 << N;

    always_comb begin
        idx = '0;
        any = |vec;
`ifdef ENCODE_MSB_FIRST_EN
        for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = i[N-1:0];
        end
`else
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[N-1:0];
        end
`endif
    end
endmodule

// File: rtl/decode_3_input_serial_encoder.sv
// Multi-hot vector to serial binary index stream, one beat per set bit.
// Default order is lowest index first; ENCODE_MSB_FIRST_EN gives highest first.
module decode_3_input_serial_encoder
    import decode_encode_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst,
    decode_3_input_serial_encoder_if.slave bus
);
    localparam int W = 1 << N;

    enc_state_t   state_q, state_d;
    logic [W-1:0] pending_q, pending_d;
    logic         zero_seen_q, zero_seen_d;

    logic [N-1:0] ffs_idx;
    logic         ffs_any;
    logic [W-1:0] sel_mask;
    logic         is_last;

    find_first_set #(.N(N)) u_ffs (
        .vec (pending_q),
        .idx (ffs_idx),
        .any (ffs_any)
    );

    assign sel_mask = W'(1) << ffs_idx;
    assign is_last  = onehot_count_is_one(MAX_W'(pending_q));

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_seen_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.en_in != '0) begin
                        pending_d = bus.en_in;
                        state_d   = BUSY;
                    end else begin
                        zero_seen_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An empty pending in BUSY is unreachable; drop back safely.
                if (!ffs_any) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    pending_d = pending_q & ~sel_mask;
                    if (is_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == BUSY);
    assign bus.enc_out   = ffs_idx;
    assign bus.out_last  = (state_q == BUSY) && is_last;
    assign bus.zero_seen = zero_seen_q;
endmodule

// File: tb/tb_decode_3_input_serial_encoder.sv
// Directed plus randomized checks of the serial encoder against a bit-list model.
// Expected order follows ENCODE_MSB_FIRST_EN when it is defined.
module tb_decode_3_input_serial_encoder;
    localparam int N = 3;
    localparam int W = 1 << N;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_q[$];

    decode_3_input_serial_encoder_if #(.N(N)) bus ();

    decode_3_input_serial_encoder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: list the set bit positions in emission order.
    task automatic model_fill(input logic [W-1:0] v);
        exp_q.delete();
        for (int i = 0; i < W; i++) begin
            if (((v >> i) & 1) != 0) begin
`ifdef ENCODE_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_last"}, 32'(bus.out_last), 0);
    endtask

    task automatic check_beat(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_enc"}, 32'(bus.enc_out), 32'(exp_q[0]));
        check({tag, "_last"}, 32'(bus.out_last),
              (exp_q.size() == 1) ? 1 : 0);
    endtask

    task automatic capture(input logic [W-1:0] v);
        bus.en_in    = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.en_in    = '0;
        model_fill(v);
    endtask

    // Drain a captured vector; stall_pct sets how often out_ready is low,
    // noise injects ignored in_valid pulses while busy.
    task automatic drain(input string tag, input int stall_pct,
                         input bit noise);
        int budget;
        bit rdy;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            check_beat(tag);
            rdy = ($urandom_range(99) >= stall_pct);
            bus.out_ready = rdy;
            if (noise) begin
                bus.in_valid = $urandom_range(1);
                bus.en_in    = W'($urandom);
            end
            step();
            bus.in_valid = 1'b0;
            if (rdy) void'(exp_q.pop_front());
            budget--;
        end
        if (budget == 0) begin
            failures++;
            $error("FAIL %s_timeout observed=stuck expected=drained", tag);
        end
        bus.out_ready = 1'b1;
        check_idle({tag, "_done"});
    endtask

    initial begin
        logic [W-1:0] v;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.en_in     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check_idle("reset");
        check("reset_enc", 32'(bus.enc_out), 0);
        check("reset_zero", 32'(bus.zero_seen), 0);
        rst = 1'b0;
        step();

        // Single bit: one beat, in_ready low for one cycle.
        capture(8'b0000_0001);
        drain("single", 0, 0);

        // Three bits back to back.
        capture(8'b1010_0100);
        drain("three", 0, 0);

        // Back-pressure: output holds stable for 4 stalled cycles.
        capture(8'b0001_1000);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_beat("hold");
            step();
        end
        drain("hold_rel", 0, 0);

        // All-zero vector: one-cycle zero_seen pulse, no beat.
        capture(8'h00);
        check("zero_pulse", 32'(bus.zero_seen), 1);
        check_idle("zero");
        step();
        check("zero_clear", 32'(bus.zero_seen), 0);
        check_idle("zero_after");

        // Reset mid-burst after two beats.
        capture(8'hFF);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check_beat("burst");
            step();
            void'(exp_q.pop_front());
        end
        check_beat("burst_pre_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_enc", 32'(bus.enc_out), 0);
        capture(8'h80);
        drain("after_rst", 0, 0);

        // Randomized vectors with stalls and ignored busy inputs.
        for (int t = 0; t < 40; t++) begin
            v = W'($urandom);
            if (t % 10 == 0) v = '0;
            capture(v);
            if (v == '0) begin
                check("rnd_zero", 32'(bus.zero_seen), 1);
                check_idle("rnd_zero");
                step();
            end else begin
                drain("rnd", 30, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
